keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 hex matrix keypad and produces one debounced key event per physical press. It is the input-side counterpart of the time-multiplexed dual seven-segment display driver: the display drives one digit at a time, and this block drives one keypad column at a time and reads the rows back. It keeps the last two keys entered as `digit_new`/`digit_old`, which connect directly to the display's two 4-bit digit inputs. It runs on the 48 MHz HSOSC clock.

## Interface
- `SCAN_DIV`, 48000: clock cycles each column is driven (1 ms); must be ≥ 4.
- `DEBOUNCE_CYCLES`, 960000: consecutive stable cycles needed to accept a press or a release (20 ms); must be ≥ 2.
- `REPEAT_CYCLES`, 24000000: auto-repeat period; used only under `KEYPAD_REPEAT_EN`.
- `clk` in 1: system clock, 48 MHz.
- `reset` in 1: synchronous, active-high.
- `rows` in 4: keypad rows, active-low, externally pulled up, asynchronous.
- `cols` out 4: column drive, one-cold (a single column low).
- `key_code` out 4: hex value of the last accepted key.
- `key_valid` out 1: one-cycle pulse when a key is accepted.
- `digit_new` out 4: most recent key.
- `digit_old` out 4: previous key.

## Operation
- `rows` passes through a 2-flop synchronizer to give `rs`. All decisions below use `rs`.
- Key map, listed as row r, columns 0..3:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- Reset state:
  - `cols`=4'b1110
  - `key_code`=0, `key_valid`=0, `digit_new`=0, `digit_old`=0
  - state SCAN, all counters 0.
- SCAN state:
  - The dwell counter counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 with `rs`==4'hF: rotate `cols` left (1110→1101→1011→0111→1110) and clear the dwell counter.
  - At SCAN_DIV-1 with `rs`!=4'hF: latch the column index and `rs`, clear the debounce counter, and go to DEBOUNCE. `cols` is frozen.
- DEBOUNCE state:
  - If `rs` equals the latched pattern and has exactly one 0 bit, increment the debounce counter.
  - If the pattern changes, goes all-high, or has more than one 0 bit: return to SCAN and advance the column. No event is produced.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a matching pattern, on the next edge:
    - `key_valid`=1
    - `key_code`=decoded key
    - `digit_old`←`digit_new`, `digit_new`←decoded key
    - clear the counter and go to HELD.
- HELD state:
  - `cols` stays frozen.
  - The counter increments while `rs`==4'hF and clears on any low row.
  - At DEBOUNCE_CYCLES-1, go to SCAN and advance the column.
  - Extra keys pressed while held are ignored and produce no event.
- `key_valid` is high for exactly one cycle per accepted press.
- Reset asserted in any state returns all outputs to their reset values on the next edge. A pending event is dropped.

## Timing
- Pin to `rs`: 2 cycles.
- DEBOUNCE entry to `key_valid` high: exactly DEBOUNCE_CYCLES cycles when `rs` is stable.
- Worst-case key detect: 4·SCAN_DIV + 2 cycles, plus DEBOUNCE_CYCLES.
- All outputs are registered; no combinational path from `rows`.
- Counter widths are $clog2 of their parameter; counters never wrap within a state.
- `digit_new`/`digit_old` change only on the `key_valid` cycle.

## Configuration
- `KEYPAD_REPEAT_EN` defined: auto-repeat is enabled in HELD.
  - A separate repeat counter runs while `rs` matches the latched pattern.
  - Every REPEAT_CYCLES it pulses `key_valid` and re-shifts the same key into the digits.
  - Any pattern change clears the repeat counter.
- `KEYPAD_REPEAT_EN` undefined: exactly one event per press. The repeat counter and the `REPEAT_CYCLES` logic are not synthesized.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=16.
- Reset, `rows`=4'hF for 40 cycles → `cols` rotates every 4 cycles starting 1110; `key_valid` never asserts; digits stay 0.
- Hold `rows`=4'b1101 only while `cols`=4'b1101 (key 5) → exactly one `key_valid`, `key_code`=5, `digit_new`=5, `digit_old`=0. Release, then press row3/col1 (key 0) → `digit_new`=0, `digit_old`=5.
- Key 9 with `rows` toggling every 3 cycles for 30 cycles, then stable → no pulse during the bounce, then exactly one pulse with `key_code`=9.
- Hold key 1, add key 2, release both; hold key A with a single 3-cycle release glitch → one pulse for 1, none for 2, and only one pulse for A.
- Two rows low in column 0 → no pulse and scanning resumes. Separately, assert `reset` 4 cycles into DEBOUNCE → no pulse, `cols`=1110, outputs 0.
- `KEYPAD_REPEAT_EN` defined, key F held for 60 cycles → pulses at detect, +16, +32, +48, each with `key_code`=F. Without the macro → exactly one pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives one 4x4 keypad column at a time, debounces presses and releases,
// and keeps the last two keys as display digits. Define KEYPAD_REPEAT_EN for auto-repeat while held.
module keypad_scanner #(
    parameter int SCAN_DIV        = 48000,
    parameter int DEBOUNCE_CYCLES = 960000,
    parameter int REPEAT_CYCLES   = 24000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    function automatic logic single_low(input logic [3:0] p);
        case (p)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
            default:                            single_low = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] p);
        case (p)
            4'b1101: low_index = 2'd1;
            4'b1011: low_index = 2'd2;
            4'b0111: low_index = 2'd3;
            default: low_index = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0: decode_key = 4'h1;  4'h1: decode_key = 4'h2;
            4'h2: decode_key = 4'h3;  4'h3: decode_key = 4'hA;
            4'h4: decode_key = 4'h4;  4'h5: decode_key = 4'h5;
            4'h6: decode_key = 4'h6;  4'h7: decode_key = 4'hB;
            4'h8: decode_key = 4'h7;  4'h9: decode_key = 4'h8;
            4'hA: decode_key = 4'h9;  4'hB: decode_key = 4'hC;
            4'hC: decode_key = 4'hE;  4'hD: decode_key = 4'h0;
            4'hE: decode_key = 4'hF;  4'hF: decode_key = 4'hD;
            default: decode_key = 4'h0;
        endcase
    endfunction

    logic [3:0]        sync1_q, sync1_d, rs_q, rs_d, pat_q, pat_d, cols_q, cols_d;
    logic [3:0]        key_code_q, key_code_d, digit_new_q, digit_new_d, digit_old_q, digit_old_d;
    logic              key_valid_q, key_valid_d;
    logic [1:0]        col_q, col_d;
    logic [SCAN_W-1:0] dwell_q, dwell_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    state_t            state_q, state_d;
    logic [3:0]        new_key_s;
    logic              advance_s, accept_s;
`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0]  rpt_q, rpt_d;
`endif

    // Next-state logic: scan, debounce and held-key tracking
    always_comb begin
        sync1_d     = rows;
        rs_d        = sync1_q;
        state_d     = state_q;
        pat_d       = pat_q;
        dwell_d     = dwell_q;
        deb_d       = deb_q;
        advance_s   = 1'b0;
        accept_s    = 1'b0;
        new_key_s   = decode_key(low_index(pat_q), col_q);
`ifdef KEYPAD_REPEAT_EN
        rpt_d       = rpt_q;
`endif
        case (state_q)
            ST_SCAN: begin
                if (dwell_q == SCAN_LAST) begin
                    dwell_d = {SCAN_W{1'b0}};
                    if (rs_q == 4'hF) begin
                        advance_s = 1'b1;
                    end else begin
                        pat_d   = rs_q;
                        deb_d   = {DEB_W{1'b0}};
                        state_d = ST_DEBOUNCE;
                    end
                end else begin
                    dwell_d = dwell_q + SCAN_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if ((rs_q == pat_q) && single_low(rs_q)) begin
                    if (deb_q == DEB_LAST) begin
                        accept_s = 1'b1;
                        deb_d    = {DEB_W{1'b0}};
                        state_d  = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                        rpt_d    = {RPT_W{1'b0}};
`endif
                    end else begin
                        deb_d = deb_q + DEB_W'(1);
                    end
                end else begin
                    state_d   = ST_SCAN;
                    advance_s = 1'b1;
                end
            end
            ST_HELD: begin
                // Release must be seen as all-high for a full debounce period
                if (rs_q == 4'hF) begin
                    if (deb_q == DEB_LAST) begin
                        deb_d     = {DEB_W{1'b0}};
                        state_d   = ST_SCAN;
                        advance_s = 1'b1;
                    end else begin
                        deb_d = deb_q + DEB_W'(1);
                    end
                end else begin
                    deb_d = {DEB_W{1'b0}};
                end
`ifdef KEYPAD_REPEAT_EN
                if (rs_q == pat_q) begin
                    if (rpt_q == RPT_LAST) begin
                        rpt_d    = {RPT_W{1'b0}};
                        accept_s = 1'b1;
                    end else begin
                        rpt_d = rpt_q + RPT_W'(1);
                    end
                end else begin
                    rpt_d = {RPT_W{1'b0}};
                end
`endif
            end
            default: begin
                state_d = ST_SCAN;
                deb_d   = {DEB_W{1'b0}};
                dwell_d = {SCAN_W{1'b0}};
            end
        endcase

        if (advance_s) begin
            col_d   = col_q + 2'd1;
            dwell_d = {SCAN_W{1'b0}};
        end else begin
            col_d   = col_q;
        end
        cols_d = ~(4'b0001 << col_d);

        if (accept_s) begin
            key_valid_d = 1'b1;
            key_code_d  = new_key_s;
            digit_old_d = digit_new_q;
            digit_new_d = new_key_s;
        end else begin
            key_valid_d = 1'b0;
            key_code_d  = key_code_q;
            digit_old_d = digit_old_q;
            digit_new_d = digit_new_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 4'hF;
            rs_q        <= 4'hF;
            pat_q       <= 4'hF;
            state_q     <= ST_SCAN;
            col_q       <= 2'd0;
            cols_q      <= 4'b1110;
            dwell_q     <= {SCAN_W{1'b0}};
            deb_q       <= {DEB_W{1'b0}};
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            digit_new_q <= 4'h0;
            digit_old_q <= 4'h0;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= {RPT_W{1'b0}};
`endif
        end else begin
            sync1_q     <= sync1_d;
            rs_q        <= rs_d;
            pat_q       <= pat_d;
            state_q     <= state_d;
            col_q       <= col_d;
            cols_q      <= cols_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            digit_new_q <= digit_new_d;
            digit_old_q <= digit_old_d;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= rpt_d;
`endif
        end
    end

    assign cols      = cols_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign digit_new = digit_new_q;
    assign digit_old = digit_old_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: physical keypad model driving rows from cols, scenario tasks and a
// key-history model (last two accepted keys) checked against every key_valid event.
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int RPT      = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols, key_code, digit_new, digit_old;
    logic       key_valid;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(RPT)) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols), .key_code(key_code),
        .key_valid(key_valid), .digit_new(digit_new), .digit_old(digit_old)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] pressed = 16'h0000;
    logic [3:0]  kmap [16];
    logic [3:0]  m_new, m_old, prev_new, prev_old;
    logic [3:0]  ev_code[$];
    logic [3:0]  ev_new[$];
    logic [3:0]  ev_old[$];
    int          ev_cyc[$];

    function automatic logic [3:0] keypad(input logic [3:0] c, input logic [15:0] p);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 16; i++)
            if (p[i] && c[i % 4] == 1'b0) r[i / 4] = 1'b0;
        return r;
    endfunction

    task automatic tick();
        logic rst_edge;
        rst_edge = reset;
        @(posedge clk);
        #1;
        cyc++;
        if (key_valid === 1'b1) begin
            ev_code.push_back(key_code);
            ev_new.push_back(digit_new);
            ev_old.push_back(digit_old);
            ev_cyc.push_back(cyc);
        end
        if (!rst_edge) begin
            checks++;
            if (key_valid !== 1'b1 && (digit_new !== prev_new || digit_old !== prev_old)) begin
                errors++;
                $display("FAIL digit_hold: digits %h/%h changed from %h/%h without key_valid",
                         digit_new, digit_old, prev_new, prev_old);
            end
        end
        prev_new = digit_new;
        prev_old = digit_old;
        rows = keypad(cols, pressed);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(3);
        reset = 1'b0;
        ev_code.delete(); ev_new.delete(); ev_old.delete(); ev_cyc.delete();
        m_new = 4'h0;
        m_old = 4'h0;
    endtask

    task automatic wait_event(input int bound, output bit got);
        int n;
        n = 0;
        while (ev_code.size() == 0 && n < bound) begin
            tick();
            n++;
        end
        got = (ev_code.size() != 0);
    endtask

    // Press key idx, wait for its event and check code and digit history against the model.
    task automatic press_expect(input string name, input int idx, output int ecyc);
        bit got;
        logic [3:0] c, nw, od;
        pressed[idx] = 1'b1;
        wait_event(100, got);
        ecyc = -1;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_detect: no key_valid within 100 cycles, required one", name);
        end else begin
            c = ev_code.pop_front(); nw = ev_new.pop_front(); od = ev_old.pop_front();
            ecyc = ev_cyc.pop_front();
            m_old = m_new;
            m_new = kmap[idx];
            checks++;
            if (c !== kmap[idx]) begin
                errors++; $display("FAIL %s_code: got %h required %h", name, c, kmap[idx]);
            end
            checks++;
            if (nw !== m_new || od !== m_old) begin
                errors++;
                $display("FAIL %s_digits: got new %h old %h required new %h old %h", name, nw, od, m_new, m_old);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (cols !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0 ||
            digit_new !== 4'h0 || digit_old !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: cols %b kv %b code %h dn %h do %h required 1110 0 0 0 0",
                     cols, key_valid, key_code, digit_new, digit_old);
        end
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp;
        do_reset();
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) tick();
            exp = 4'hF;
            exp[(k / SCAN_DIV) % 4] = 1'b0;
            checks++;
            if (cols !== exp) begin
                errors++; $display("FAIL idle_cols: cycle %0d got %b required %b", k, cols, exp);
            end
        end
        checks++;
        if (ev_code.size() != 0 || digit_new !== 4'h0 || digit_old !== 4'h0) begin
            errors++;
            $display("FAIL idle_quiet: events %0d digits %h/%h required 0 events digits 0/0",
                     ev_code.size(), digit_new, digit_old);
        end
    endtask

    task automatic release_quiet(input string name, input int n);
        pressed = 16'h0000;
        ticks(n);
        checks++;
        if (ev_code.size() != 0) begin
            errors++; $display("FAIL %s_extra: got %0d extra events required 0", name, ev_code.size());
            ev_code.delete(); ev_new.delete(); ev_old.delete(); ev_cyc.delete();
        end
    endtask

    task automatic test_single();
        int t;
        press_expect("key5", 5, t);
        ticks(10);
        release_quiet("key5", 20);
        press_expect("key0", 13, t);
        ticks(10);
        release_quiet("key0", 20);
    endtask

    task automatic test_bounce();
        int t;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) pressed[10] = ~pressed[10];
            tick();
        end
        checks++;
        if (ev_code.size() != 0) begin
            errors++; $display("FAIL bounce_quiet: got %0d events during bounce required 0", ev_code.size());
            ev_code.delete(); ev_new.delete(); ev_old.delete(); ev_cyc.delete();
        end
        press_expect("key9", 10, t);
        ticks(10);
        release_quiet("key9", 20);
    endtask

    task automatic test_multi();
        int t;
        press_expect("key1", 0, t);
        pressed[1] = 1'b1;
        ticks(10);
        release_quiet("key2_ignored", 20);
        press_expect("keyA", 3, t);
        ticks(5);
        pressed[3] = 1'b0;
        ticks(3);
        pressed[3] = 1'b1;
        ticks(10);
        release_quiet("keyA_glitch", 20);
    endtask

    task automatic test_two_rows();
        logic [3:0] seen;
        seen = 4'h0;
        pressed = 16'h0011;
        for (int i = 0; i < 60; i++) begin
            tick();
            for (int c = 0; c < 4; c++) if (cols[c] == 1'b0) seen[c] = 1'b1;
        end
        checks++;
        if (seen !== 4'hF) begin
            errors++; $display("FAIL two_rows_scan: columns seen %b required 1111", seen);
        end
        release_quiet("two_rows", 20);
    endtask

    task automatic test_reset_mid();
        pressed = 16'h0001;
        do_reset();
        ticks(8);
        checks++;
        if (cols !== 4'b1110 || ev_code.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_pre: cols %b events %0d required 1110 and 0", cols, ev_code.size());
        end
        reset = 1'b1;
        tick();
        checks++;
        if (cols !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0 ||
            digit_new !== 4'h0 || digit_old !== 4'h0 || ev_code.size() != 0) begin
            errors++;
            $display("FAIL reset_mid: cols %b kv %b code %h dn %h do %h events %0d required 1110 0 0 0 0 0",
                     cols, key_valid, key_code, digit_new, digit_old, ev_code.size());
        end
        pressed = 16'h0000;
        do_reset();
        release_quiet("reset_mid_after", 20);
    endtask

    task automatic test_repeat();
        int t0;
        logic [3:0] c;
        press_expect("keyF", 14, t0);
        ticks(60);
`ifdef KEYPAD_REPEAT_EN
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (ev_code.size() == 0) begin
                errors++; $display("FAIL repeat_count: repeat %0d missing", k);
            end else begin
                c = ev_code.pop_front();
                void'(ev_new.pop_front());
                void'(ev_old.pop_front());
                t0 = t0;
                checks++;
                if (c !== 4'hF || ev_cyc[0] !== t0 + k * RPT) begin
                    errors++;
                    $display("FAIL repeat_event: code %h at +%0d required F at +%0d", c, ev_cyc[0] - t0, k * RPT);
                end
                void'(ev_cyc.pop_front());
            end
        end
        m_old = 4'hF;
`endif
        release_quiet("keyF_hold", 20);
    endtask

    task automatic test_random();
        int idx, t;
        for (int n = 0; n < 12; n++) begin
            idx = $urandom_range(0, 15);
            for (int b = $urandom_range(0, 4); b > 0; b--) begin
                pressed[idx] = ~pressed[idx];
                ticks($urandom_range(1, 3));
            end
            press_expect("random", idx, t);
            ticks($urandom_range(0, 8));
            release_quiet("random", $urandom_range(14, 25));
        end
    endtask

    initial begin
        kmap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                 4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
        rows = 4'hF;
        reset = 1'b1;
        prev_new = 4'h0;
        prev_old = 4'h0;
        test_reset();
        test_idle_scan();
        test_single();
        test_bounce();
        test_multi();
        test_two_rows();
        test_reset_mid();
        test_repeat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
